// File: rtl/img_bram_to_axis.sv
// Reads a frame of NUM_WORDS words from a BRAM port and replays it as an
// AXI-Stream frame through a 2-entry skid FIFO.
module img_bram_to_axis #(
    parameter int          NUM_WORDS = 784,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic        clkb,
    output logic        rstb,
    output logic        enb,
    output logic [31:0] addrb,
    output logic [31:0] dinb,
    output logic [3:0]  web,
    input  logic [31:0] doutb,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_start_q;
    logic          r_arm;
    logic          r_go;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_addr;
    logic          r_vld;
    logic          r_vlast;
    logic [31:0]   r_mem [2];
    logic [1:0]    r_lst;
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;

    logic       w_tick;
    logic       w_launch;
    logic       w_pop;
    logic [2:0] w_level;
    logic       w_room;
    logic       w_issue;
    logic       w_is_last;
    logic       w_head_last;

    // r_arm masks the first cycle after reset so a held start is not an edge
    assign w_tick    = start & ~r_start_q & r_arm;
    assign w_launch  = (r_state == IDLE) & w_tick;
    assign w_pop     = (r_cnt != 2'd0) & m_axis_tready;
    assign w_level   = {1'b0, r_cnt} + {2'b00, r_vld}
                     - {2'b00, w_pop};
    assign w_room    = (w_level < 3'd2);
    assign w_issue   = (r_state == RUN) & r_go & w_room;
    assign w_is_last = (r_idx == LAST_IDX);
    assign w_head_last = r_lst[r_rp];

    assign clkb  = clk;
    assign rstb  = ~rst_n;
    assign addrb = r_addr;
    assign dinb  = 32'd0;
    assign web   = 4'd0;

    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign m_axis_tdata  = r_mem[r_rp];
    assign m_axis_tlast  = m_axis_tvalid & w_head_last;

    always_comb begin
        w_next = r_state;
        enb    = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                done = 1'b1;
                if (w_tick) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                enb = w_issue;
                if (w_issue && w_is_last) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_pop && w_head_last) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_arm     <= 1'b0;
            r_go      <= 1'b0;
            r_idx     <= '0;
            r_addr    <= BASE_ADDR;
            r_vld     <= 1'b0;
            r_vlast   <= 1'b0;
            r_mem[0]  <= 32'd0;
            r_mem[1]  <= 32'd0;
            r_lst     <= 2'b00;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
            r_arm     <= 1'b1;
            // one cycle of address setup before the first read of a frame
            r_go      <= (r_state == RUN);
            if (w_launch) begin
                r_idx  <= '0;
                r_addr <= BASE_ADDR;
            end else if (w_issue && !w_is_last) begin
                r_idx  <= r_idx + 1'b1;
                r_addr <= r_addr + 32'd4;
            end
            r_vld   <= w_issue;
            r_vlast <= w_issue & w_is_last;
            if (r_vld) begin
                r_mem[r_wp] <= doutb;
                r_lst[r_wp] <= r_vlast;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, r_vld} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_img_bram_to_axis.sv
// Bench for img_bram_to_axis: a 784-word instance and a 1-word instance,
// each fed by a behavioural BRAM, checked against frame-order expectations.
module tb_img_bram_to_axis;

    localparam int          N   = 784;
    localparam logic [31:0] B1  = 32'h40;
    localparam logic [31:0] K1  = 32'hCAFE0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        clkb;
    logic        rstb;
    logic        enb;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic [3:0]  web;
    logic [31:0] doutb;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    logic        s_start;
    logic        s_done;
    logic        s_clkb;
    logic        s_rstb;
    logic        s_enb;
    logic [31:0] s_addrb;
    logic [31:0] s_dinb;
    logic [3:0]  s_web;
    logic [31:0] s_doutb;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;

    int errors;
    int checks;

    img_bram_to_axis #(.NUM_WORDS(N), .BASE_ADDR(32'd0)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .clkb(clkb), .rstb(rstb), .enb(enb), .addrb(addrb),
        .dinb(dinb), .web(web), .doutb(doutb),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    img_bram_to_axis #(.NUM_WORDS(1), .BASE_ADDR(B1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(s_start), .done(s_done),
        .clkb(s_clkb), .rstb(s_rstb), .enb(s_enb), .addrb(s_addrb),
        .dinb(s_dinb), .web(s_web), .doutb(s_doutb),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid),
        .m_axis_tready(s_tready), .m_axis_tlast(s_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM contents: big word i holds i; small BRAM holds addr ^ K1
    always @(posedge clk) begin
        if (enb) doutb <= addrb >> 2;
        if (s_enb) s_doutb <= s_addrb ^ K1;
    end

    task automatic step(input bit rdy);
        @(posedge clk);
        #1 tready = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0);
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_stream got v=%b l=%b d=%h want 0 0 0",
                     tvalid, tlast, tdata);
        end
        checks++;
        if (done !== 1'b1 || enb !== 1'b0 || addrb !== 32'd0) begin
            errors++;
            $display("FAIL reset_bram got done=%b enb=%b addr=%h want 1 0 0",
                     done, enb, addrb);
        end
        checks++;
        if (rstb !== 1'b1 || dinb !== 32'd0 || web !== 4'd0
            || clkb !== clk) begin
            errors++;
            $display("FAIL reset_ties got rstb=%b din=%h web=%h clkb=%b",
                     rstb, dinb, web, clkb);
        end
        checks++;
        if (s_done !== 1'b1 || s_addrb !== B1 || s_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_one got done=%b addr=%h v=%b want 1 %h 0",
                     s_done, s_addrb, s_tvalid, B1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            checks++;
            if (done !== 1'b1 || enb !== 1'b0 || tvalid !== 1'b0) begin
                errors++;
                $display("FAIL held_start c%0d got done=%b enb=%b v=%b",
                         i, done, enb, tvalid);
            end
        end
        checks++;
        if (rstb !== 1'b0) begin
            errors++;
            $display("FAIL rstb_run got %b want 0", rstb);
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    task automatic test_stream(input int mode, input bit glitch);
        int beats, reads, cyc, low, first_v, st_reads;
        logic pv, pr, pl;
        logic [31:0] pd, last_a;
        bit rdy;
        beats = 0; reads = 0; cyc = 0; low = 0;
        first_v = -1; st_reads = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; last_a = '0;
        rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode != 2);
        start = 1'b1;
        step(rdy);
        start = 1'b0;
        while (cyc < 4 * N + 100) begin
            if (!done) low++;
            if (tvalid && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold c%0d got v=%b d=%0d want 1 %0d",
                             cyc, tvalid, tdata, pd);
                end
            end
            checks++;
            if (reads - beats > 2) begin
                errors++;
                $display("FAIL occupancy c%0d got %0d want <=2",
                         cyc, reads - beats);
            end
            if (tvalid) begin
                checks++;
                if (tlast !== (tdata == 32'(N - 1))) begin
                    errors++;
                    $display("FAIL tlast c%0d got %b for word %0d",
                             cyc, tlast, tdata);
                end
            end
            if (enb) begin
                checks++;
                if (addrb !== 32'(4 * reads)) begin
                    errors++;
                    $display("FAIL addr c%0d got %0d want %0d",
                             cyc, addrb, 4 * reads);
                end
                last_a = addrb;
                reads++;
                if (mode == 2 && cyc < 20) st_reads++;
            end
            if (tvalid && tready) begin
                checks++;
                if (tdata !== 32'(beats)) begin
                    errors++;
                    $display("FAIL beat %0d got %0d want %0d",
                             beats, tdata, beats);
                end
                beats++;
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            start = glitch && (beats == 50);
            if (beats == N && done) break;
            cyc++;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else if (mode == 2) rdy = (cyc >= 20);
            else rdy = 1'b1;
            step(rdy);
        end
        start = 1'b0;
        checks++;
        if (beats != N || reads != N) begin
            errors++;
            $display("FAIL frame_len m%0d got beats=%0d reads=%0d want %0d",
                     mode, beats, reads, N);
        end
        checks++;
        if (last_a !== 32'd3132) begin
            errors++;
            $display("FAIL last_addr got %0d want 3132", last_a);
        end
        if (mode != 1) begin
            checks++;
            if (first_v != 3) begin
                errors++;
                $display("FAIL first_valid got %0d want 3", first_v);
            end
        end
        if (mode == 0) begin
            checks++;
            if (low != N + 3) begin
                errors++;
                $display("FAIL done_low got %0d want %0d", low, N + 3);
            end
        end
        if (mode == 2) begin
            checks++;
            if (st_reads != 2) begin
                errors++;
                $display("FAIL stall_reads got %0d want 2", st_reads);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_stream(0, 1'b1);
        test_stream(0, 1'b0);
    endtask

    task automatic test_abort();
        int beats;
        int cyc;
        beats = 0;
        cyc = 0;
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        while (beats < 100 && cyc < 400) begin
            if (tvalid && tready) begin
                checks++;
                if (tdata !== 32'(beats)) begin
                    errors++;
                    $display("FAIL abort_beat %0d got %0d", beats, tdata);
                end
                beats++;
            end
            cyc++;
            if (beats < 100) step(1'b1);
        end
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        checks++;
        if (tvalid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort got v=%b done=%b want 0 1", tvalid, done);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            checks++;
            if (tvalid !== 1'b0 || enb !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c%0d got v=%b enb=%b",
                         i, tvalid, enb);
            end
        end
        test_stream(0, 1'b0);
    endtask

    task automatic test_single();
        int beats, low;
        beats = 0;
        low = 0;
        s_start = 1'b1;
        step(1'b1);
        s_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!s_done) low++;
            if (s_enb) begin
                checks++;
                if (s_addrb !== B1) begin
                    errors++;
                    $display("FAIL one_addr got %h want %h", s_addrb, B1);
                end
            end
            if (s_tvalid && s_tready) begin
                checks++;
                if (s_tdata !== (B1 ^ K1) || s_tlast !== 1'b1) begin
                    errors++;
                    $display("FAIL one_beat got d=%h l=%b want %h 1",
                             s_tdata, s_tlast, B1 ^ K1);
                end
                beats++;
            end
            step(1'b1);
        end
        checks++;
        if (beats != 1 || low != 4 || s_done !== 1'b1) begin
            errors++;
            $display("FAIL one_frame got beats=%0d low=%0d done=%b",
                     beats, low, s_done);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        tready   = 1'b0;
        doutb    = '0;
        s_doutb  = '0;
        s_start  = 1'b0;
        s_tready = 1'b1;
        test_reset();
        test_stream(0, 1'b0);
        test_stream(1, 1'b0);
        test_stream(2, 1'b0);
        test_back_to_back();
        test_abort();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_bram_to_axis.md
IMG_BRAM_TO_AXIS -- requirements
Module: img_bram_to_axis

Interface
REQ-001 Parameter NUM_WORDS, default 784, number of 32-bit words read per frame (one pixel per word).
REQ-002 Parameter BASE_ADDR, default 0, byte address of word 0 in the source BRAM.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level; a rising edge launches one frame transfer.
REQ-006 done  output  1  high when idle, low while a frame is in progress.
REQ-007 clkb  output  1  BRAM clock, SHALL equal clk.
REQ-008 rstb  output  1  BRAM reset, SHALL equal ~rst_n.
REQ-009 enb  output  1  BRAM enable; high only on read-issue cycles.
REQ-010 addrb  output  32  BRAM byte address, registered.
REQ-011 dinb  output  32  constant 0.
REQ-012 web  output  4  constant 0; the block never writes.
REQ-013 doutb  input  32  BRAM read data, valid one cycle after the enb/addrb cycle.
REQ-014 m_axis_tdata  output  32  stream data (the BRAM word, unmodified).
REQ-015 m_axis_tvalid  output  1  stream valid.
REQ-016 m_axis_tready  input  1  stream ready from the consumer.
REQ-017 m_axis_tlast  output  1  high on the final word of the frame.

Function
REQ-018 The block SHALL register start and form start_tick = start & ~start_q.
REQ-019 FSM states SHALL be IDLE, RUN and FLUSH.
- IDLE -> RUN on start_tick.
- RUN -> FLUSH when read NUM_WORDS-1 is issued.
- FLUSH -> IDLE on the cycle the tlast beat handshakes (tvalid & tready).
REQ-020 start_tick in RUN or FLUSH SHALL be ignored.
REQ-021 Read i (0..NUM_WORDS-1) SHALL use addrb = BASE_ADDR + 4*i, issued in ascending order with no gaps and no repeats.
REQ-022 Reads SHALL be captured into a 2-entry output FIFO one cycle after issue.
REQ-023 A read SHALL be issued only when FIFO occupancy plus in-flight reads, minus any pop this cycle, is less than 2.
REQ-024 No word SHALL be dropped or duplicated under any tready pattern.
REQ-025 m_axis_tvalid = FIFO non-empty; m_axis_tdata = FIFO head.
REQ-026 Once m_axis_tvalid is high, it and m_axis_tdata SHALL stay stable until a handshake occurs.
REQ-027 m_axis_tlast SHALL be high exactly when the head is word NUM_WORDS-1, and low otherwise.
REQ-028 With tready held high, the first tvalid SHALL rise exactly 3 cycles after the edge that samples start_tick.
REQ-029 With tready held high, one beat SHALL be accepted per cycle thereafter; the frame takes NUM_WORDS+3 cycles total.
REQ-030 Simultaneous push and pop on a full FIFO SHALL keep occupancy 2.
REQ-031 Simultaneous push and pop on an empty FIFO SHALL NOT pass data combinationally from doutb to tdata.
REQ-032 done SHALL go low on the cycle after start_tick and SHALL return high on the cycle after the tlast handshake.
REQ-033 A new start_tick SHALL be accepted from the cycle done returns high.
REQ-034 Index and occupancy counters SHALL be wide enough for NUM_WORDS up to 65536 with no wrap.
REQ-035 The index counter SHALL reset to 0 at each frame start.

Reset
REQ-036 While rst_n=0 at a clk edge, all of the following SHALL hold:
- state = IDLE; FIFO emptied; in-flight reads discarded.
- addrb = BASE_ADDR; enb = 0.
- m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0.
- start_q = 0; done = 1.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no further beats emitted.
REQ-038 After such an abort, a fresh start rising edge SHALL restart from word 0.
REQ-039 start held high through reset release SHALL NOT trigger a frame until it falls and rises again.

Verification
REQ-040 NUM_WORDS=784, BRAM word i = i, tready=1, start pulse -> 784 beats with tdata 0..783; tlast on beat 783 only; done low for 787 cycles; addrb last = 3132.
REQ-041 Same setup, tready random at 50% -> identical data sequence, no duplicates, tdata/tvalid stable while stalled, FIFO occupancy never exceeds 2.
REQ-042 tready=0 for 20 cycles right after start -> exactly 2 reads issued, enb then low, tvalid held on word 0; on release, words 1..783 follow in order.
REQ-043 rst_n pulsed low at beat 100 -> tvalid=0 and done=1 on the next cycle; a new start then streams from word 0 with tdata=0.
REQ-044 Second start edge at beat 50 -> ignored, frame completes normally; start edge one cycle after done rises -> second full frame.
REQ-045 NUM_WORDS=1 -> a single beat with tdata=word 0 and tlast=1, then done=1.
